// File: rtl/mem_pkg.sv
// Shared types for the pipelined main-memory model.
// Read slots carry a valid bit plus one memory word.
package mem_pkg;
   localparam int WORD_W = 16;
   localparam int MAX_LATENCY = 8;

   typedef logic [WORD_W-1:0] mem_word_t;

   typedef struct packed {
      logic      valid;
      mem_word_t data;
   } rd_slot_t;
endpackage

// File: rtl/mem_pipelined_if.sv
// Request/response bundle between a cache controller (master)
// and the pipelined memory (slave).
interface mem_pipelined_if #(
   parameter int ADDR_W = 16
) ();
   import mem_pkg::*;

   logic              enable;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   mem_word_t         data_in;
   mem_word_t         data_out;
   logic              data_valid;
   logic              busy;

   modport master (
      output enable, wr, addr, data_in,
      input  data_out, data_valid, busy
   );

   modport slave (
      input  enable, wr, addr, data_in,
      output data_out, data_valid, busy
   );
endinterface

// File: rtl/mem_lat_pipe.sv
// LATENCY-stage shift register of read slots; sync reset
// clears every stage so in-flight reads are dropped.
module mem_lat_pipe
   import mem_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  rd_slot_t           in_slot,
   output rd_slot_t           out_slot,
   output logic [LATENCY-1:0] valid_vec
);

   rd_slot_t stage_q [LATENCY];
   rd_slot_t stage_d [LATENCY];

   always_comb begin
      stage_d[0] = in_slot;
      for (int i = 1; i < LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= '{default: '0};
      end else begin
         stage_q <= stage_d;
      end
   end

   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < LATENCY; i++) begin
         valid_vec[i] = stage_q[i].valid;
      end
   end

   assign out_slot = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_pipelined.sv
// Fixed-latency, fully pipelined 16-bit word memory.
// Define MEM_STATS_EN to add saturating rd_count/wr_count outputs.
module mem_pipelined
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 32768,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_pipelined_if.slave    bus
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   mem_word_t         mem_q [DEPTH];
   logic [ADDR_W-1:0] addr;
   logic [IDX_W-1:0]  idx;
   logic              rd_acc;
   logic              wr_acc;
   rd_slot_t          in_slot;
   rd_slot_t          out_slot;
   logic [LATENCY-1:0] vld;
   logic              addr_unused;

   assign addr = bus.addr;
   assign addr_unused = ^addr;

   // Requests during reset are dropped, including writes.
   always_comb begin
      rd_acc       = bus.enable & ~bus.wr & ~rst;
      wr_acc       = bus.enable & bus.wr & ~rst;
      idx          = addr[IDX_W:1];
      in_slot      = '0;
      in_slot.valid = rd_acc;
      if (rd_acc) begin
         in_slot.data = mem_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[idx] <= bus.data_in;
      end
   end

   mem_lat_pipe #(
      .LATENCY (LATENCY)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_slot   (in_slot),
      .out_slot  (out_slot),
      .valid_vec (vld)
   );

   assign bus.data_valid = out_slot.valid;
   assign bus.data_out   = out_slot.valid ? out_slot.data : '0;
   assign bus.busy       = |vld;

`ifdef MEM_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (rd_acc && rd_count_q != 16'hFFFF) begin
         rd_count_d = rd_count_q + 16'd1;
      end
      if (wr_acc && wr_count_q != 16'hFFFF) begin
         wr_count_d = wr_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_pipelined.sv
// Scoreboard bench for mem_pipelined: reads push expected words
// and due cycles; a negedge monitor pops and checks them.
module tb_mem_pipelined;

   localparam int LAT = 4;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   mon_on = 1'b0;

   logic [15:0] model [32768];
   exp_t        sb [$];
   exp_t        e;
   logic        exp_busy;

   mem_pipelined_if #(.ADDR_W(16)) bus ();

`ifdef MEM_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   int          n_rd = 0;
   int          n_wr = 0;
`endif

   mem_pipelined #(
      .ADDR_W  (16),
      .DEPTH   (32768),
      .LATENCY (LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus)
`ifdef MEM_STATS_EN
      ,
      .rd_count (rd_count),
      .wr_count (wr_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      bus.enable = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one request for one cycle; scoreboard updated after
   // the acceptance edge so cyc already names that edge.
   task automatic do_op(input logic w, input logic [15:0] a,
                        input logic [15:0] d);
      exp_t x;
      bus.enable  = 1'b1;
      bus.wr      = w;
      bus.addr    = a;
      bus.data_in = d;
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
      if (w) begin
         model[a[15:1]] = d;
`ifdef MEM_STATS_EN
         n_wr++;
`endif
      end else begin
         x.data = model[a[15:1]];
         x.due  = cyc + LAT - 1;
         sb.push_back(x);
`ifdef MEM_STATS_EN
         n_rd++;
`endif
      end
   endtask

   // A write is presented during reset and must be ignored.
   task automatic do_reset(input int n);
      rst         = 1'b1;
      bus.enable  = 1'b1;
      bus.wr      = 1'b1;
      bus.addr    = 16'h0000;
      bus.data_in = 16'hDEAD;
      @(posedge clk);
      #1;
      sb.delete();
`ifdef MEM_STATS_EN
      n_rd = 0;
      n_wr = 0;
`endif
      repeat (n - 1) begin
         @(posedge clk);
         #1;
      end
      rst        = 1'b0;
      bus.enable = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         exp_busy = (sb.size() != 0);
         if (bus.data_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_dv", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rd_data", bus.data_out, e.data);
               chk("rd_cycle", cyc, e.due);
            end
         end else begin
            chk("idle_zero", bus.data_out, 16'h0000);
            if (sb.size() != 0 && sb[0].due < cyc) begin
               chk("missing_dv", cyc, sb[0].due);
               void'(sb.pop_front());
            end
         end
         chk("busy", bus.busy, exp_busy);
      end
   end

   initial begin
      bus.enable  = 1'b0;
      bus.wr      = 1'b0;
      bus.addr    = '0;
      bus.data_in = '0;
      @(posedge clk);
      #1;
      do_op(1'b1, 16'h0000, 16'h1234);
      do_reset(2);
      chk("rst_data_out", bus.data_out, 16'h0000);
      chk("rst_data_valid", bus.data_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      mon_on = 1'b1;

      do_op(1'b0, 16'h0000, 16'h0000);
      drain();
      idle(2);

      for (int i = 0; i < 8; i++) begin
         do_op(1'b1, 16'h0080 + 16'(2 * i), 16'hA000 + 16'(i));
      end
      for (int i = 0; i < 8; i++) begin
         bus.enable = 1'b1;
         do_op(1'b0, 16'h0080 + 16'(2 * i), 16'h0000);
      end
      drain();
      idle(2);

      do_op(1'b1, 16'h0040, 16'hABCD);
      do_op(1'b0, 16'h0040, 16'h0000);
      drain();
      chk("raw_model", model[16'h0040 >> 1], 16'hABCD);

      for (int i = 0; i < 32; i++) begin
         do_op(1'b1, 16'h0100 + 16'(2 * i), 16'($urandom));
      end
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 7) begin
            do_op(1'($urandom), 16'h0100 + 16'($urandom_range(0, 63)),
                  16'($urandom));
         end else begin
            idle(1);
         end
      end
      drain();
      idle(2);

      do_op(1'b0, 16'h0080, 16'h0000);
      do_op(1'b0, 16'h0082, 16'h0000);
      do_op(1'b0, 16'h0084, 16'h0000);
      do_reset(1);
      chk("midrst_busy", bus.busy, 1'b0);
      idle(10);
      chk("midrst_busy_late", bus.busy, 1'b0);

`ifdef MEM_STATS_EN
      for (int i = 0; i < 5; i++) do_op(1'b0, 16'h0100, 16'h0000);
      for (int i = 0; i < 3; i++) do_op(1'b1, 16'h0102, 16'h5555);
      drain();
      chk("rd_count", rd_count, 16'(n_rd));
      chk("wr_count", wr_count, 16'(n_wr));
      chk("rd_count_5", rd_count, 16'd5);
      dut.wr_count_q = 16'hFFFF;
      do_op(1'b1, 16'h0104, 16'h1111);
      chk("wr_count_sat", wr_count, 16'hFFFF);
      do_reset(1);
      chk("stats_rst_rd", rd_count, 16'h0000);
      chk("stats_rst_wr", wr_count, 16'h0000);
`endif

      idle(2);
      mon_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout sim stuck at cyc %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
